dm_arbiter: RTL and testbench

- Arbitrates the single data-memory port between two requesters:
  - the core's data address generator (port C);
  - an external/debug loader (port X).
- Sits between `core_top`'s load/store path and the DM instance.
- Core has priority, X may hold a locked burst, and read data is routed back to the requester that issued the read.
- One access per cycle; the memory has a 1-cycle synchronous read latency.

---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_arb_rdroute.sv | 47 ++++
 rtl/dm_arbiter.sv | 158 +++++++++++++++
 tb/tb_dm_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    XBURST = 1'b1
  } state_e;

  // Requester IDs carried by the read-return owner register
  localparam logic REQ_C = 1'b0;
  localparam logic REQ_X = 1'b1;

  localparam int unsigned DEF_DMA_SIZE     = 16;
  localparam int unsigned DEF_DMD_SIZE     = 16;
  localparam int unsigned DEF_MAX_BURST    = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/dm_arb_rdroute.sv
// Read-return pipeline: remembers who issued the read and steers dm_rdata back one cycle later.
module dm_arb_rdroute
  import dm_arb_pkg::*;
#(
  parameter int unsigned DMD_SIZE = DEF_DMD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_fire_i,
  input  logic                rd_owner_i,
  input  logic [DMD_SIZE-1:0] dm_rdata_i,
  output logic                c_rvalid_o,
  output logic                x_rvalid_o,
  output logic [DMD_SIZE-1:0] c_rdata_o,
  output logic [DMD_SIZE-1:0] x_rdata_o
);

  logic valid_q, valid_d;
  logic owner_q, owner_d;

  // Capture each granted read; owner holds when idle
  always_comb begin
    valid_d = rd_fire_i;
    owner_d = owner_q;
    if (rd_fire_i) owner_d = rd_owner_i;
  end

  // Owner/valid register; reset drops any read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      owner_q <= REQ_C;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  // Demux memory data to the owner; the other port reads zero
  always_comb begin
    c_rvalid_o = valid_q && (owner_q == REQ_C);
    x_rvalid_o = valid_q && (owner_q == REQ_X);
    c_rdata_o  = c_rvalid_o ? dm_rdata_i : '0;
    x_rdata_o  = x_rvalid_o ? dm_rdata_i : '0;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between the core (C) and an external/debug loader (X).
// Optional X anti-starvation is enabled by defining DM_ARB_FAIRNESS_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned DMA_SIZE     = DEF_DMA_SIZE,
  parameter int unsigned DMD_SIZE     = DEF_DMD_SIZE,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [DMA_SIZE-1:0] c_addr,
  input  logic [DMD_SIZE-1:0] c_wdata,
  input  logic                x_req,
  input  logic                x_we,
  input  logic [DMA_SIZE-1:0] x_addr,
  input  logic [DMD_SIZE-1:0] x_wdata,
  input  logic                x_lock,
  output logic                c_gnt,
  output logic                x_gnt,
  output logic                c_rvalid,
  output logic                x_rvalid,
  output logic [DMD_SIZE-1:0] c_rdata,
  output logic [DMD_SIZE-1:0] x_rdata,
  output logic                dm_en,
  output logic                dm_we,
  output logic [DMA_SIZE-1:0] dm_addr,
  output logic [DMD_SIZE-1:0] dm_wdata,
  input  logic [DMD_SIZE-1:0] dm_rdata
);

  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

  state_e              state_q, state_d;
  logic [BC_W-1:0]     burst_q, burst_d;
  logic                force_x;
  logic                dm_we_q, dm_we_d;
  logic [DMA_SIZE-1:0] dm_addr_q, dm_addr_d;
  logic [DMD_SIZE-1:0] dm_wdata_q, dm_wdata_d;

`ifdef DM_ARB_FAIRNESS_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_q, starve_d;

  assign force_x = (starve_q == SC_W'(STARVE_LIMIT));

  // Count denied X cycles in ARB; any X grant clears, saturate at the limit
  always_comb begin
    starve_d = starve_q;
    if (x_gnt) begin
      starve_d = '0;
    end else if ((state_q == ARB) && x_req && (starve_q < SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_starve;

  assign unused_starve = (STARVE_LIMIT == 0);
  assign force_x       = 1'b0;
`endif

  // Arbitration and burst FSM; grants are forced low while in reset
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    c_gnt   = 1'b0;
    x_gnt   = 1'b0;
    case (state_q)
      ARB: begin
        if (x_req && (force_x || !c_req)) x_gnt = 1'b1;
        else if (c_req)                   c_gnt = 1'b1;
        if (x_gnt && x_lock && (MAX_BURST > 1)) begin
          state_d = XBURST;
          burst_d = BC_W'(1);
        end
      end
      XBURST: begin
        x_gnt = x_req;
        if (x_gnt) burst_d = burst_q + BC_W'(1);
        if (!x_lock || !x_req || (burst_d == BC_W'(MAX_BURST))) begin
          state_d = ARB;
          burst_d = '0;
        end
      end
      default: begin
        state_d = ARB;
        burst_d = '0;
      end
    endcase
    if (reset) begin
      c_gnt = 1'b0;
      x_gnt = 1'b0;
    end
  end

  // Memory command mux; without a grant the bus holds its last command
  always_comb begin
    dm_en      = c_gnt || x_gnt;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    if (x_gnt) begin
      dm_we_d    = x_we;
      dm_addr_d  = x_addr;
      dm_wdata_d = x_wdata;
    end else if (c_gnt) begin
      dm_we_d    = c_we;
      dm_addr_d  = c_addr;
      dm_wdata_d = c_wdata;
    end
    dm_we    = dm_we_d;
    dm_addr  = dm_addr_d;
    dm_wdata = dm_wdata_d;
  end

  // FSM, burst counter and held memory command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      burst_q    <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  dm_arb_rdroute #(
    .DMD_SIZE (DMD_SIZE)
  ) u_rdroute (
    .clk        (clk),
    .reset      (reset),
    .rd_fire_i  (dm_en && !dm_we),
    .rd_owner_i (x_gnt ? REQ_X : REQ_C),
    .dm_rdata_i (dm_rdata),
    .c_rvalid_o (c_rvalid),
    .x_rvalid_o (x_rvalid),
    .c_rdata_o  (c_rdata),
    .x_rdata_o  (x_rdata)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed stimulus pushes expected grants/reads,
// a negedge monitor pops and compares whenever the DUT grants or returns data.
module tb_dm_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef struct {
    bit          who;
    int unsigned cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gnt_t;

  typedef struct {
    bit          who;
    int unsigned cyc;
    logic [15:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, x_req, x_we, x_lock;
  logic [AW-1:0] c_addr, x_addr;
  logic [DW-1:0] c_wdata, x_wdata;
  logic          c_gnt, x_gnt, c_rvalid, x_rvalid;
  logic [DW-1:0] c_rdata, x_rdata;
  logic          dm_en, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  gnt_t        exp_g[$];
  rd_t         exp_r[$];
  logic [15:0] mem [0:255];

`ifdef DM_ARB_FAIRNESS_EN
  localparam int C_LEN = 11;
  localparam int X_LEN = 5;
  localparam int X_AT  = 4;
`else
  localparam int C_LEN = 10;
  localparam int X_LEN = 11;
  localparam int X_AT  = 10;
`endif

  dm_arbiter #(
    .DMA_SIZE     (AW),
    .DMD_SIZE     (DW),
    .MAX_BURST    (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .x_req    (x_req),
    .x_we     (x_we),
    .x_addr   (x_addr),
    .x_wdata  (x_wdata),
    .x_lock   (x_lock),
    .c_gnt    (c_gnt),
    .x_gnt    (x_gnt),
    .c_rvalid (c_rvalid),
    .x_rvalid (x_rvalid),
    .c_rdata  (c_rdata),
    .x_rdata  (x_rdata),
    .dm_en    (dm_en),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (16'hA000 | a);
  endfunction

  // Synchronous memory model with 1-cycle read latency
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(16'(i));
    end else if (dm_en) begin
      if (dm_we) mem[dm_addr[7:0]] <= dm_wdata;
      else       dm_rdata <= mem[dm_addr[7:0]];
    end
  end

  // Requester protocol: a pending request must stay up with a stable command
  logic        pc_pend = 1'b0, px_pend = 1'b0;
  logic [32:0] pc_cmd, px_cmd;
  always @(posedge clk) begin
    if (!reset) begin
      if (pc_pend)
        assert (c_req && {c_we, c_addr, c_wdata} == pc_cmd)
        else begin errors++; $display("FAIL c_protocol req=%b cmd=%h held=%h", c_req, {c_we, c_addr, c_wdata}, pc_cmd); end
      if (px_pend)
        assert (x_req && {x_we, x_addr, x_wdata} == px_cmd)
        else begin errors++; $display("FAIL x_protocol req=%b cmd=%h held=%h", x_req, {x_we, x_addr, x_wdata}, px_cmd); end
    end
    pc_pend = !reset && c_req && !c_gnt;
    px_pend = !reset && x_req && !x_gnt;
    pc_cmd  = {c_we, c_addr, c_wdata};
    px_cmd  = {x_we, x_addr, x_wdata};
  end

  // Monitor: pop expectations on every grant / rvalid; check idle bus holds
  logic        last_we = 1'b0;
  logic [15:0] last_addr = '0, last_wdata = '0;
  always @(negedge clk) begin
    gnt_t g;
    rd_t  r;
    if (reset) begin
      last_we = 1'b0; last_addr = '0; last_wdata = '0;
    end
    if (c_gnt && x_gnt) begin
      checks++; errors++;
      $display("FAIL both_gnt cyc=%0d got c_gnt=1 x_gnt=1, want at most one", cyc);
    end
    if (c_gnt || x_gnt) begin
      checks++;
      if (exp_g.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected cyc=%0d got c_gnt=%b x_gnt=%b, want none", cyc, c_gnt, x_gnt);
      end else begin
        g = exp_g.pop_front();
        if (x_gnt != g.who || cyc != g.cyc || !dm_en || dm_we != g.we ||
            dm_addr != g.addr || dm_wdata != g.wdata) begin
          errors++;
          $display("FAIL gnt cyc=%0d got who=%0d en=%b we=%b addr=%h wd=%h, want cyc=%0d who=%0d en=1 we=%b addr=%h wd=%h",
                   cyc, x_gnt, dm_en, dm_we, dm_addr, dm_wdata, g.cyc, g.who, g.we, g.addr, g.wdata);
        end
        last_we = g.we; last_addr = g.addr; last_wdata = g.wdata;
      end
    end else begin
      checks++;
      if (dm_en || dm_we != last_we || dm_addr != last_addr || dm_wdata != last_wdata) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got en=%b we=%b addr=%h wd=%h, want en=0 we=%b addr=%h wd=%h",
                 cyc, dm_en, dm_we, dm_addr, dm_wdata, last_we, last_addr, last_wdata);
      end
    end
    if (c_rvalid || x_rvalid) begin
      checks++;
      if (c_rvalid && x_rvalid) begin
        errors++;
        $display("FAIL both_rvalid cyc=%0d got c_rvalid=1 x_rvalid=1", cyc);
      end else if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected cyc=%0d got c_rvalid=%b x_rvalid=%b, want none", cyc, c_rvalid, x_rvalid);
      end else begin
        r = exp_r.pop_front();
        if (x_rvalid != r.who || cyc != r.cyc ||
            (x_rvalid ? x_rdata : c_rdata) != r.data) begin
          errors++;
          $display("FAIL rdata cyc=%0d got who=%0d data=%h, want cyc=%0d who=%0d data=%h",
                   cyc, x_rvalid, x_rvalid ? x_rdata : c_rdata, r.cyc, r.who, r.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    c_req = req; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic set_x(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic lock);
    x_req = req; x_we = we; x_addr = a; x_wdata = d; x_lock = lock;
  endtask

  task automatic push_g(input bit who, input logic we, input logic [15:0] a, input logic [15:0] d);
    gnt_t g;
    g.who = who; g.cyc = cyc; g.we = we; g.addr = a; g.wdata = d;
    exp_g.push_back(g);
  endtask

  task automatic push_r(input bit who, input logic [15:0] d);
    rd_t r;
    r.who = who; r.cyc = cyc + 1; r.data = d;
    exp_r.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c_gnt"},    32'(c_gnt),    32'h0);
    chk({tag, "_x_gnt"},    32'(x_gnt),    32'h0);
    chk({tag, "_c_rvalid"}, 32'(c_rvalid), 32'h0);
    chk({tag, "_x_rvalid"}, 32'(x_rvalid), 32'h0);
    chk({tag, "_dm_en"},    32'(dm_en),    32'h0);
    chk({tag, "_dm_we"},    32'(dm_we),    32'h0);
    chk({tag, "_dm_addr"},  32'(dm_addr),  32'h0);
    chk({tag, "_dm_wdata"}, 32'(dm_wdata), 32'h0);
    chk({tag, "_c_rdata"},  32'(c_rdata),  32'h0);
    chk({tag, "_x_rdata"},  32'(x_rdata),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] xa;
    // Reset with requests up: grants must stay low
    reset = 1'b1;
    set_c(1'b1, 1'b0, 16'h0010, 16'h0);
    set_x(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    step; reset = 1'b0;
    set_c(1'b0, 1'b0, 16'h0, 16'h0);
    set_x(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step;

    // Single C read of 0x0010
    step; set_c(1'b1, 1'b0, 16'h0010, 16'h0);
    push_g(1'b0, 1'b0, 16'h0010, 16'h0); push_r(1'b0, 16'hBEEF);
    step; set_c(1'b0, 1'b0, 16'h0010, 16'h0);
    step;

    // Contention: C priority (or forced X beat with fairness)
    for (int i = 0; i < 11; i++) begin
      step;
      set_c(i < C_LEN, 1'b0, 16'h0020, 16'h0);
      set_x(i < X_LEN, 1'b0, 16'h0030, 16'h0, 1'b0);
      if (i == X_AT) begin
        push_g(1'b1, 1'b0, 16'h0030, 16'h0); push_r(1'b1, init_val(16'h0030));
      end else if (i < C_LEN) begin
        push_g(1'b0, 1'b0, 16'h0020, 16'h0); push_r(1'b0, init_val(16'h0020));
      end
    end
    step; set_c(1'b0, 1'b0, 16'h0, 16'h0); set_x(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step;

    // Locked X burst of 12 reads against a C request from the second cycle
    for (int i = 0; i < 14; i++) begin
      step;
      xa = (i <= 8) ? 16'(16'h0040 + i) : 16'(16'h0040 + i - 1);
      set_x(i < 13, 1'b0, xa, 16'h0, 1'b1);
      set_c((i >= 1) && (i <= 8), 1'b0, 16'h0050, 16'h0);
      if (i == 8) begin
        push_g(1'b0, 1'b0, 16'h0050, 16'h0); push_r(1'b0, init_val(16'h0050));
      end else if (i < 13) begin
        push_g(1'b1, 1'b0, xa, 16'h0); push_r(1'b1, init_val(xa));
      end
    end
    step; set_x(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step;

    // Interleaved: X read then C write, then C read-back of the written word
    step; set_x(1'b1, 1'b0, 16'h0060, 16'h0, 1'b0);
    push_g(1'b1, 1'b0, 16'h0060, 16'h0); push_r(1'b1, init_val(16'h0060));
    step; set_x(1'b0, 1'b0, 16'h0060, 16'h0, 1'b0);
    set_c(1'b1, 1'b1, 16'h0061, 16'h1234);
    push_g(1'b0, 1'b1, 16'h0061, 16'h1234);
    step; set_c(1'b1, 1'b0, 16'h0061, 16'h0);
    push_g(1'b0, 1'b0, 16'h0061, 16'h0); push_r(1'b0, 16'h1234);
    step; set_c(1'b0, 1'b0, 16'h0, 16'h0);
    step;

    // Reset one cycle after an X read grant: read is dropped
    step; set_x(1'b1, 1'b0, 16'h0070, 16'h0, 1'b0);
    push_g(1'b1, 1'b0, 16'h0070, 16'h0);
    step; reset = 1'b1; set_x(1'b1, 1'b0, 16'h0071, 16'h0, 1'b1);
    @(negedge clk);
    chk_all_zero("midreset");
    step; set_x(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step; reset = 1'b0;
    repeat (4) step;

    chk("exp_gnt_left", 32'(exp_g.size()), 32'h0);
    chk("exp_rd_left",  32'(exp_r.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
